// File: rtl/rs_decode_sequencer.sv
// Reed-Solomon decode sequencer: steps syndrome, Berlekamp-Massey, Chien
// search and Forney stages in order. It issues one-cycle CE pulses, waits
// for each stage's done pulse, bounds every stage with a timeout, and
// reports one status word per codeword.
module rs_decode_sequencer #(
  parameter int MAX_ERR = 8,
  parameter int TIMEOUT = 1023,
  parameter int TW      = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       syn_done,
  input  logic       syn_zero,
  input  logic       bm_done,
  input  logic [3:0] lam_deg,
  input  logic       roots_done,
  input  logic [3:0] root_cnt,
  input  logic       forney_done,
  output logic       syn_ce,
  output logic       bm_ce,
  output logic       roots_ce,
  output logic       forney_ce,
  output logic       busy,
  output logic       done,
  output logic [1:0] status,
  output logic [3:0] err_cnt,
  output logic       start_drop
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SYN    = 3'd1,
    S_BM     = 3'd2,
    S_ROOTS  = 3'd3,
    S_FORNEY = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [1:0] ST_CLEAN   = 2'b00;
  localparam logic [1:0] ST_CORR    = 2'b01;
  localparam logic [1:0] ST_UNCORR  = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b11;

  // The timer holds the number of completed cycles in the current stage, so
  // the stage expires when the count is about to reach TIMEOUT.
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  state_t        state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [3:0]    deg_reg, deg_next;

  // Completion code chosen by the next-state logic when heading to DONE.
  logic [1:0]    fin_status;
  logic [3:0]    fin_err;
  logic          in_stage;
  logic          timed_out;

  // Registered-output next values.
  logic          syn_ce_next, bm_ce_next, roots_ce_next, forney_ce_next;
  logic          busy_next, done_next, start_drop_next;
  logic [1:0]    status_next;
  logic [3:0]    err_cnt_next;

  assign in_stage  = (state_reg == S_SYN) || (state_reg == S_BM) ||
                     (state_reg == S_ROOTS) || (state_reg == S_FORNEY);
  assign timed_out = in_stage && (timer_reg == TIMER_LAST);

  // State, timer, latched degree and all outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      timer_reg  <= '0;
      deg_reg    <= '0;
      syn_ce     <= 1'b0;
      bm_ce      <= 1'b0;
      roots_ce   <= 1'b0;
      forney_ce  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      status     <= 2'b00;
      err_cnt    <= 4'd0;
      start_drop <= 1'b0;
    end else begin
      state_reg  <= state_next;
      timer_reg  <= timer_next;
      deg_reg    <= deg_next;
      syn_ce     <= syn_ce_next;
      bm_ce      <= bm_ce_next;
      roots_ce   <= roots_ce_next;
      forney_ce  <= forney_ce_next;
      busy       <= busy_next;
      done       <= done_next;
      status     <= status_next;
      err_cnt    <= err_cnt_next;
      start_drop <= start_drop_next;
    end
  end

  // Next-state decision: a stage's own done input beats its timeout; done
  // inputs belonging to other stages are not looked at.
  always_comb begin
    state_next = state_reg;
    deg_next   = deg_reg;
    fin_status = ST_CLEAN;
    fin_err    = 4'd0;
    case (state_reg)
      S_IDLE: begin
        if (start) state_next = S_SYN;
      end
      S_SYN: begin
        if (syn_done) begin
          if (syn_zero) begin
            state_next = S_DONE;
            fin_status = ST_CLEAN;
          end else begin
            state_next = S_BM;
          end
        end else if (timed_out) begin
          state_next = S_DONE;
          fin_status = ST_TIMEOUT;
        end
      end
      S_BM: begin
        if (bm_done) begin
          if ((lam_deg == 4'd0) || (32'(lam_deg) > MAX_ERR)) begin
            state_next = S_DONE;
            fin_status = ST_UNCORR;
          end else begin
            deg_next   = lam_deg;
            state_next = S_ROOTS;
          end
        end else if (timed_out) begin
          state_next = S_DONE;
          fin_status = ST_TIMEOUT;
        end
      end
      S_ROOTS: begin
        if (roots_done) begin
          if (root_cnt != deg_reg) begin
            state_next = S_DONE;
            fin_status = ST_UNCORR;
          end else begin
            state_next = S_FORNEY;
          end
        end else if (timed_out) begin
          state_next = S_DONE;
          fin_status = ST_TIMEOUT;
        end
      end
      S_FORNEY: begin
        if (forney_done) begin
          state_next = S_DONE;
          fin_status = ST_CORR;
          fin_err    = deg_reg;
        end else if (timed_out) begin
          state_next = S_DONE;
          fin_status = ST_TIMEOUT;
        end
      end
      S_DONE: begin
        // A start landing on the report cycle chains straight into SYN.
        state_next = start ? S_SYN : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    // Timer restarts on any state entry and only runs while a stage works.
    if ((state_next != state_reg) || !in_stage) timer_next = '0;
    else                                        timer_next = timer_reg + 1'b1;
  end

  // Output decode: CE pulses fire only on entry to a stage, so a held done
  // input can never stretch them.
  always_comb begin
    syn_ce_next     = (state_next == S_SYN)    && (state_reg != S_SYN);
    bm_ce_next      = (state_next == S_BM)     && (state_reg != S_BM);
    roots_ce_next   = (state_next == S_ROOTS)  && (state_reg != S_ROOTS);
    forney_ce_next  = (state_next == S_FORNEY) && (state_reg != S_FORNEY);
    busy_next       = (state_next != S_IDLE);
    done_next       = (state_next == S_DONE);
    start_drop_next = start && in_stage;
    status_next     = done_next ? fin_status : status;
    err_cnt_next    = done_next ? fin_err    : err_cnt;
  end

endmodule

// File: tb/tb_rs_decode_sequencer.sv
// Testbench for rs_decode_sequencer: directed decodes; a monitor matches
// every CE / done / start_drop pulse against a queue of expected events
// (kind, cycle, status, err_cnt) pushed by the stimulus.
module tb_rs_decode_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, syn_done, syn_zero, bm_done, roots_done, forney_done;
  logic [3:0] lam_deg, root_cnt;
  logic       syn_ce, bm_ce, roots_ce, forney_ce, busy, done, start_drop;
  logic [1:0] status;
  logic [3:0] err_cnt;

  rs_decode_sequencer #(.MAX_ERR(8), .TIMEOUT(20), .TW(10)) dut (
    .clk(clk), .reset(reset), .start(start),
    .syn_done(syn_done), .syn_zero(syn_zero),
    .bm_done(bm_done), .lam_deg(lam_deg),
    .roots_done(roots_done), .root_cnt(root_cnt),
    .forney_done(forney_done),
    .syn_ce(syn_ce), .bm_ce(bm_ce), .roots_ce(roots_ce), .forney_ce(forney_ce),
    .busy(busy), .done(done), .status(status), .err_cnt(err_cnt),
    .start_drop(start_drop)
  );

  always #5 clk = ~clk;

  // Cycle number of the most recent rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int K_SYN = 0, K_BM = 1, K_ROOTS = 2, K_FORNEY = 3, K_DONE = 4, K_DROP = 5;

  typedef struct {
    int         kind;
    int         at;
    logic [1:0] st;
    logic [3:0] err;
  } ev_t;

  ev_t q[$];
  int  n_vec = 0;
  int  n_bad = 0;

  function automatic string kname(input int k);
    case (k)
      K_SYN:    return "syn_ce";
      K_BM:     return "bm_ce";
      K_ROOTS:  return "roots_ce";
      K_FORNEY: return "forney_ce";
      K_DONE:   return "done";
      default:  return "start_drop";
    endcase
  endfunction

  task automatic push_ev(input int kind, input int at,
                         input logic [1:0] st = 2'b00, input logic [3:0] err = 4'd0);
    ev_t e;
    e.kind = kind; e.at = at; e.st = st; e.err = err;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per observed pulse; overdue entries are misses.
  always @(negedge clk) begin
    logic [5:0] seen;
    ev_t        e;
    seen = {start_drop, done, forney_ce, roots_ce, bm_ce, syn_ce};
    while (q.size() > 0 && q[0].at < cyc) begin
      e = q.pop_front();
      n_vec++; n_bad++;
      $display("FAIL missing_%s: not seen, want cycle %0d (now %0d)", kname(e.kind), e.at, cyc);
    end
    for (int k = 0; k < 6; k++) begin
      if (seen[k]) begin
        n_vec++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_%s: got pulse at cycle %0d, want none", kname(k), cyc);
        end else begin
          e = q.pop_front();
          if (e.kind != k || e.at != cyc ||
              (k == K_DONE && (status !== e.st || err_cnt !== e.err))) begin
            n_bad++;
            $display("FAIL event_%s: got %s@%0d st=%b err=%0d, want %s@%0d st=%b err=%0d",
                     kname(e.kind), kname(k), cyc, status, err_cnt,
                     kname(e.kind), e.at, e.st, e.err);
          end else begin
            $display("ok %s at cycle %0d st=%b err=%0d", kname(k), cyc, status, err_cnt);
          end
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic p_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask
  task automatic p_syn(input logic zero);
    syn_done = 1'b1; syn_zero = zero; tick(); syn_done = 1'b0; syn_zero = 1'b0;
  endtask
  task automatic p_bm(input logic [3:0] deg);
    bm_done = 1'b1; lam_deg = deg; tick(); bm_done = 1'b0; lam_deg = 4'd0;
  endtask
  task automatic p_roots(input logic [3:0] cnt);
    roots_done = 1'b1; root_cnt = cnt; tick(); roots_done = 1'b0; root_cnt = 4'd0;
  endtask
  task automatic p_forney();
    forney_done = 1'b1; tick(); forney_done = 1'b0;
  endtask

  // Start, syndrome nonzero, then BM reports the given degree.
  task automatic run_to_bm(input logic [3:0] deg, input int expect_roots);
    push_ev(K_SYN, cyc + 1); p_start(); tick(2);
    push_ev(K_BM, cyc + 1);  p_syn(1'b0); tick(3);
    if (expect_roots != 0) push_ev(K_ROOTS, cyc + 1);
    else                   push_ev(K_DONE, cyc + 1, 2'b10, 4'd0);
    p_bm(deg);
  endtask

  // Full correction path ending in status 01.
  task automatic full_correct(input logic [3:0] deg);
    run_to_bm(deg, 1); tick(4);
    push_ev(K_FORNEY, cyc + 1); p_roots(deg); tick(2);
    push_ev(K_DONE, cyc + 1, 2'b01, deg); p_forney(); tick(3);
    chk("corr_status_hold", {30'd0, status}, 32'd1);
    chk("corr_err_hold", {28'd0, err_cnt}, {28'd0, deg});
    chk("corr_idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    reset = 1'b1; start = 1'b0; syn_done = 1'b0; syn_zero = 1'b0; bm_done = 1'b0;
    roots_done = 1'b0; forney_done = 1'b0; lam_deg = 4'd0; root_cnt = 4'd0;
    tick(3);
    chk("reset_outputs", {busy, done, status, err_cnt, syn_ce, bm_ce, roots_ce, forney_ce, start_drop}, 32'd0);
    reset = 1'b0; tick(2);

    // Clean codeword: only syn_ce, then done with 00.
    push_ev(K_SYN, cyc + 1); p_start(); tick(4);
    push_ev(K_DONE, cyc + 1, 2'b00, 4'd0); p_syn(1'b1); tick(2);
    chk("clean_busy_drop", {31'd0, busy}, 32'd0);

    // Three errors, then the largest correctable count.
    full_correct(4'd3);
    full_correct(4'd8);

    // Root count mismatch.
    run_to_bm(4'd4, 1); tick(3);
    push_ev(K_DONE, cyc + 1, 2'b10, 4'd0); p_roots(4'd2); tick(3);
    chk("mismatch_status", {30'd0, status}, 32'd2);

    // Degree beyond MAX_ERR, and degree zero: uncorrectable straight from BM.
    run_to_bm(4'd9, 0); tick(3);
    chk("deg9_status", {30'd0, status}, 32'd2);
    run_to_bm(4'd0, 0); tick(3);

    // Timeout in ROOTS: done 20 cycles after the roots_ce cycle.
    run_to_bm(4'd5, 1);
    r = cyc;
    push_ev(K_DONE, r + 20, 2'b11, 4'd0);
    tick(24);
    chk("timeout_status", {30'd0, status}, 32'd3);
    chk("timeout_busy", {31'd0, busy}, 32'd0);

    // roots_done in the last allowed cycle beats the timeout.
    run_to_bm(4'd5, 1);
    r = cyc;
    tick(19);
    push_ev(K_FORNEY, r + 20); p_roots(4'd5); tick(2);
    push_ev(K_DONE, cyc + 1, 2'b01, 4'd5); p_forney(); tick(2);

    // start during BM is dropped, decode completes.
    push_ev(K_SYN, cyc + 1); p_start(); tick(2);
    push_ev(K_BM, cyc + 1); p_syn(1'b0); tick(1);
    push_ev(K_DROP, cyc + 1); p_start();
    chk("drop_busy", {31'd0, busy}, 32'd1);
    tick(2);
    push_ev(K_ROOTS, cyc + 1); p_bm(4'd2); tick(2);
    push_ev(K_FORNEY, cyc + 1); p_roots(4'd2); tick(2);
    push_ev(K_DONE, cyc + 1, 2'b01, 4'd2); p_forney();

    // start on the DONE cycle chains into a new decode without dropping busy.
    tick(2);
    run_to_bm(4'd1, 1); tick(2);
    push_ev(K_FORNEY, cyc + 1); p_roots(4'd1); tick(2);
    push_ev(K_DONE, cyc + 1, 2'b01, 4'd1); p_forney();
    chk("chain_done_cycle", {31'd0, done}, 32'd1);
    chk("chain_busy_done", {31'd0, busy}, 32'd1);
    push_ev(K_SYN, cyc + 1); p_start();
    chk("chain_busy_syn", {31'd0, busy}, 32'd1);
    tick(2);
    push_ev(K_DONE, cyc + 1, 2'b00, 4'd0); p_syn(1'b1); tick(2);

    // Reset mid-ROOTS aborts; a stray roots_done afterwards is ignored.
    run_to_bm(4'd3, 1); tick(2);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("abort_outputs", {busy, done, status, err_cnt, syn_ce, bm_ce, roots_ce, forney_ce, start_drop}, 32'd0);
    tick();
    p_roots(4'd3); tick(3);
    chk("abort_stay_idle", {31'd0, busy}, 32'd0);
    full_correct(4'd2);

    tick(3);
    chk("queue_drained", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
